// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between the pipeline EX stage (req 0) and
// the aux/debug port (req 1). Round-robin arbitration with valid/ready
// handshakes, one operation in flight, mul sequenced by a latency counter.
//
// Build option: ALU_ARB_FIXED_PRIO_EN -- when defined, req 0 always wins ties
// and last_grant is ignored. Req 1 can then starve.
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   req_valid_i / req_ready_o     per-requester handshake (ready is combinational)
//   req{0,1}_ctrl/data1/data2_i   per-requester operation payload
//   alu_ctrl/data1/data2_o        to ALU; non-zero only while executing
//   alu_data_i                    ALU result
//   resp_valid_o / resp_ready_i   result handshake
//   resp_id_o, resp_data_o        owner and value of the result
//   busy_o                        FSM not idle
module alu_share_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       req_valid_i,
   output logic [1:0]       req_ready_o,
   input  logic [3:0]       req0_ctrl_i,
   input  logic [WIDTH-1:0] req0_data1_i,
   input  logic [WIDTH-1:0] req0_data2_i,
   input  logic [3:0]       req1_ctrl_i,
   input  logic [WIDTH-1:0] req1_data1_i,
   input  logic [WIDTH-1:0] req1_data2_i,
   output logic [3:0]       alu_ctrl_o,
   output logic [WIDTH-1:0] alu_data1_o,
   output logic [WIDTH-1:0] alu_data2_o,
   input  logic [WIDTH-1:0] alu_data_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_id_o,
   output logic [WIDTH-1:0] resp_data_o,
   output logic             busy_o
);

   localparam int unsigned CNT_W    = 4;
   localparam logic [3:0]  CTRL_MUL = 4'b0101;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_EXEC = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

   logic [1:0]       state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [3:0]       alu_ctrl_q, alu_ctrl_d;
   logic [WIDTH-1:0] alu_data1_q, alu_data1_d;
   logic [WIDTH-1:0] alu_data2_q, alu_data2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             resp_valid_q, resp_valid_d;
   logic             resp_id_q, resp_id_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;
   logic             busy_q, busy_d;

   logic             tie_pick;
   logic             winner;
   logic [1:0]       ready_c;
   logic             accept;
   logic [3:0]       sel_ctrl;
   logic [WIDTH-1:0] sel_data1;
   logic [WIDTH-1:0] sel_data2;

   // Tie-break choice
`ifdef ALU_ARB_FIXED_PRIO_EN
   assign tie_pick = 1'b0;
`else
   assign tie_pick = ~last_grant_q;
`endif

   // Winner and combinational grant; ready is forced low while reset is held
   always_comb begin
      winner  = 1'b0;
      ready_c = 2'b00;
      case (req_valid_i)
         2'b10:   winner = 1'b1;
         2'b11:   winner = tie_pick;
         default: winner = 1'b0;
      endcase
      if ((state_q == ST_IDLE) && !rst_i && (req_valid_i != 2'b00)) begin
         ready_c = winner ? 2'b10 : 2'b01;
      end
   end

   assign accept    = |(req_valid_i & ready_c);
   assign sel_ctrl  = winner ? req1_ctrl_i  : req0_ctrl_i;
   assign sel_data1 = winner ? req1_data1_i : req0_data1_i;
   assign sel_data2 = winner ? req1_data2_i : req0_data2_i;

   // Next-state logic; the op registers double as the ALU drive and are
   // cleared outside EXEC so the ALU inputs stay quiet
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      alu_ctrl_d   = alu_ctrl_q;
      alu_data1_d  = alu_data1_q;
      alu_data2_d  = alu_data2_q;
      cnt_d        = cnt_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      busy_d       = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d      = ST_EXEC;
               last_grant_d = winner;
               resp_id_d    = winner;
               alu_ctrl_d   = sel_ctrl;
               alu_data1_d  = sel_data1;
               alu_data2_d  = sel_data2;
               cnt_d        = (sel_ctrl == CTRL_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
               busy_d       = 1'b1;
            end
         end
         ST_EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d      = ST_RESP;
               resp_data_d  = alu_data_i;
               resp_valid_d = 1'b1;
               alu_ctrl_d   = '0;
               alu_data1_d  = '0;
               alu_data2_d  = '0;
            end
         end
         ST_RESP: begin
            if (resp_ready_i) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b0;
               busy_d       = 1'b0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
            busy_d       = 1'b0;
            alu_ctrl_d   = '0;
            alu_data1_d  = '0;
            alu_data2_d  = '0;
         end
      endcase
   end

   // State registers; last_grant resets to 1 so req 0 wins the first tie
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         alu_ctrl_q   <= '0;
         alu_data1_q  <= '0;
         alu_data2_q  <= '0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         alu_ctrl_q   <= alu_ctrl_d;
         alu_data1_q  <= alu_data1_d;
         alu_data2_q  <= alu_data2_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
         busy_q       <= busy_d;
      end
   end

   assign req_ready_o  = ready_c;
   assign alu_ctrl_o   = alu_ctrl_q;
   assign alu_data1_o  = alu_data1_q;
   assign alu_data2_o  = alu_data2_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_id_o    = resp_id_q;
   assign resp_data_o  = resp_data_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: table of single-requester operations plus
// directed sequences for round-robin, backpressure, async reset and a
// withdrawn request. A small ALU model drives alu_data_i; its mul result is
// only correct once the operands have been held for MUL_LAT cycles.
module tb_alu_share_arbiter;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned MUL_LAT = 3;

   logic             clk;
   logic             rst_i;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready_o;
   logic [3:0]       req0_ctrl, req1_ctrl;
   logic [WIDTH-1:0] req0_d1, req0_d2, req1_d1, req1_d2;
   logic [3:0]       alu_ctrl_o;
   logic [WIDTH-1:0] alu_data1_o, alu_data2_o;
   logic [WIDTH-1:0] alu_data;
   logic             resp_valid_o;
   logic             resp_ready;
   logic             resp_id_o;
   logic [WIDTH-1:0] resp_data_o;
   logic             busy_o;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready_o),
      .req0_ctrl_i  (req0_ctrl),
      .req0_data1_i (req0_d1),
      .req0_data2_i (req0_d2),
      .req1_ctrl_i  (req1_ctrl),
      .req1_data1_i (req1_d1),
      .req1_data2_i (req1_d2),
      .alu_ctrl_o   (alu_ctrl_o),
      .alu_data1_o  (alu_data1_o),
      .alu_data2_o  (alu_data2_o),
      .alu_data_i   (alu_data),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready),
      .resp_id_o    (resp_id_o),
      .resp_data_o  (resp_data_o),
      .busy_o       (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU model: 0 and, 1 or, 2 xor, 3 add, 4 sub, 5 mul (multi-cycle), else 0
   int mul_age;
   always @(posedge clk) begin
      if (alu_ctrl_o == 4'b0101) mul_age <= mul_age + 1;
      else                       mul_age <= 0;
   end
   always_comb begin
      case (alu_ctrl_o)
         4'b0000: alu_data = alu_data1_o & alu_data2_o;
         4'b0001: alu_data = alu_data1_o | alu_data2_o;
         4'b0010: alu_data = alu_data1_o ^ alu_data2_o;
         4'b0011: alu_data = alu_data1_o + alu_data2_o;
         4'b0100: alu_data = alu_data1_o - alu_data2_o;
         4'b0101: alu_data = (mul_age >= int'(MUL_LAT) - 1) ?
                             32'(alu_data1_o * alu_data2_o) : 32'hDEAD_BEEF;
         default: alu_data = '0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0]  valid;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_data;
      logic        exp_id;
      int          exp_lat;
   } vec_t;

   vec_t vecs[8];

   task automatic do_reset;
      rst_i      = 1'b1;
      req_valid  = 2'b00;
      resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      @(posedge clk); #1;
   endtask

   // Wait (bounded) for resp_valid at negedges; k = cycles waited, 0 on timeout
   task automatic wait_resp(output int k);
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (resp_valid_o) begin
            k = c;
            break;
         end
      end
      if (k == 0) chk("resp_timeout", 32'(resp_valid_o), 32'd1);
   endtask

   // One single-requester transaction, entered just after a rising edge in IDLE
   task automatic run_txn(input int idx, input vec_t v);
      int k;
      req_valid = v.valid;
      if (v.valid == 2'b01) begin
         req0_ctrl = v.ctrl;  req0_d1 = v.a;  req0_d2 = v.b;
         req1_ctrl = ~v.ctrl; req1_d1 = ~v.a; req1_d2 = ~v.b;
      end else begin
         req1_ctrl = v.ctrl;  req1_d1 = v.a;  req1_d2 = v.b;
         req0_ctrl = ~v.ctrl; req0_d1 = ~v.a; req0_d2 = ~v.b;
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready", idx), 32'(req_ready_o), v.exp_id ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_idle_busy", idx), 32'(busy_o), 32'd0);
      chk($sformatf("v%0d_idle_alu", idx), 32'(alu_ctrl_o) | alu_data1_o, 32'd0);
      @(posedge clk); #1;
      req_valid = 2'b00;
      k = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (resp_valid_o) begin
            k = c;
            break;
         end
         chk($sformatf("v%0d_exec_ctrl", idx), 32'(alu_ctrl_o), 32'(v.ctrl));
         chk($sformatf("v%0d_exec_d1", idx), alu_data1_o, v.a);
         chk($sformatf("v%0d_exec_d2", idx), alu_data2_o, v.b);
         chk($sformatf("v%0d_exec_busy", idx), 32'(busy_o), 32'd1);
      end
      chk($sformatf("v%0d_latency", idx), 32'(k), 32'(v.exp_lat));
      if (k != 0) begin
         chk($sformatf("v%0d_data", idx), resp_data_o, v.exp_data);
         chk($sformatf("v%0d_id", idx), 32'(resp_id_o), 32'(v.exp_id));
         chk($sformatf("v%0d_resp_alu", idx), 32'(alu_ctrl_o) | alu_data1_o | alu_data2_o, 32'd0);
         chk($sformatf("v%0d_resp_busy", idx), 32'(busy_o), 32'd1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_valid", idx), 32'(resp_valid_o), 32'd0);
      chk($sformatf("v%0d_done_busy", idx), 32'(busy_o), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [1:0] exp_g;

      vecs[0] = '{2'b01, 4'b0011, 32'd5,          32'd7,          32'd12,         1'b0, 2};
      vecs[1] = '{2'b10, 4'b0101, 32'd3,          32'hFFFF_FFFC,  32'hFFFF_FFF4,  1'b1, 1 + MUL_LAT};
      vecs[2] = '{2'b01, 4'b0100, 32'd10,         32'd3,          32'd7,          1'b0, 2};
      vecs[3] = '{2'b10, 4'b0010, 32'h0000_00F0,  32'h0000_00FF,  32'h0000_000F,  1'b1, 2};
      vecs[4] = '{2'b01, 4'b1111, 32'd9,          32'd9,          32'd0,          1'b0, 2};
      vecs[5] = '{2'b01, 4'b0101, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b0, 1 + MUL_LAT};
      vecs[6] = '{2'b10, 4'b0011, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1, 2};
      vecs[7] = '{2'b10, 4'b1011, 32'h1234_5678,  32'h0000_0001,  32'd0,          1'b1, 2};

      rst_i = 1'b1; req_valid = 2'b00; resp_ready = 1'b1;
      req0_ctrl = '0; req0_d1 = '0; req0_d2 = '0;
      req1_ctrl = '0; req1_d1 = '0; req1_d2 = '0;

      // Reset state
      #3;
      chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_outputs", 32'(alu_ctrl_o) | alu_data1_o | alu_data2_o | resp_data_o | 32'(resp_id_o), 32'd0);
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      do_reset();

      // Table of single-requester operations
      for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

      // Round-robin with both requesters continuously valid
      do_reset();
      req0_ctrl = 4'b0100; req0_d1 = 32'd10;   req0_d2 = 32'd3;
      req1_ctrl = 4'b0010; req1_d1 = 32'hF0;   req1_d2 = 32'hFF;
      req_valid = 2'b11;
      for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_g = 2'b01;
`else
         exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
`endif
         k = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready_o != 2'b00) break;
            k++;
         end
         chk($sformatf("rr%0d_grant", g), 32'(req_ready_o), 32'(exp_g));
         @(posedge clk); #1;
         if (g == 3) req_valid = 2'b00;
         wait_resp(k);
         chk($sformatf("rr%0d_id", g), 32'(resp_id_o), exp_g[1] ? 32'd1 : 32'd0);
         chk($sformatf("rr%0d_data", g), resp_data_o, exp_g[1] ? 32'h0F : 32'd7);
      end
      @(posedge clk); #1;

      // Backpressure: result held while resp_ready is low, req 1 waits
      resp_ready = 1'b0;
      req0_ctrl = 4'b0011; req0_d1 = 32'd5; req0_d2 = 32'd7;
      req_valid = 2'b01;
      @(negedge clk);
      chk("bp_ready0", 32'(req_ready_o), 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b10;
      wait_resp(k);
      chk("bp_latency", 32'(k), 32'd2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d_valid", c), 32'(resp_valid_o), 32'd1);
         chk($sformatf("bp_hold%0d_data", c), resp_data_o, 32'd12);
         chk($sformatf("bp_hold%0d_id", c), 32'(resp_id_o), 32'd0);
         chk($sformatf("bp_hold%0d_ready", c), 32'(req_ready_o), 32'd0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_ready", 32'(req_ready_o), 32'd0);
      chk("bp_hs_valid", 32'(resp_valid_o), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_after_valid", 32'(resp_valid_o), 32'd0);
      chk("bp_after_ready", 32'(req_ready_o), 32'd2);
      @(posedge clk); #1;
      req_valid = 2'b00;
      wait_resp(k);
      chk("bp_req1_id", 32'(resp_id_o), 32'd1);
      chk("bp_req1_data", resp_data_o, 32'h0F);
      @(posedge clk); #1;

      // Withdrawn request: valid dropped before any edge, nothing latched
      req_valid = 2'b10;
      #2;
      req_valid = 2'b00;
      @(negedge clk);
      chk("wd_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wd_busy", 32'(busy_o), 32'd0);
      chk("wd_alu", 32'(alu_ctrl_o), 32'd0);
      @(posedge clk); #1;

      // Async reset during the second EXEC cycle of a mul
      req0_ctrl = 4'b0101; req0_d1 = 32'd3; req0_d2 = 32'hFFFF_FFFC;
      req_valid = 2'b01;
      @(posedge clk); #1;
      req0_ctrl = 4'b0011; req0_d1 = 32'd5; req0_d2 = 32'd7;
      req_valid = 2'b11;
      @(negedge clk);
      chk("ar_exec1_ctrl", 32'(alu_ctrl_o), 32'h5);
      @(posedge clk); #1;
      rst_i = 1'b1;
      #1;
      chk("ar_busy", 32'(busy_o), 32'd0);
      chk("ar_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("ar_alu", 32'(alu_ctrl_o) | alu_data1_o | alu_data2_o, 32'd0);
      chk("ar_resp", resp_data_o | 32'(resp_id_o), 32'd0);
      chk("ar_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      chk("ar_tie_ready", 32'(req_ready_o), 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      wait_resp(k);
      chk("ar_latency", 32'(k), 32'd2);
      chk("ar_id", 32'(resp_id_o), 32'd0);
      chk("ar_data", resp_data_o, 32'd12);
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
